board_store: RTL and testbench
==============================

Name: board_store

Overview:
- Holds the 64-square chess board state and is the receiving end of the board write port driven by game_logic (board_out_addr / board_out_piece / board_change_enable).
- Returns the whole board to game_logic as a flattened 256-bit bus.
- Loads the standard starting position, one square per cycle, after reset or on a new-game request.
- Provides a registered single-square read port for the display path.

Parameters:
- PIECE_W, 4, square width in bits: {color, 3-bit piece type}. Fixed at 4. Other values are unsupported.
- CLEAR_ONLY, 0, when 1 the init sequence loads an empty board (all 4'b0000) instead of the start position.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous reset, active-low.
- new_game  in  1  single-cycle request to reload the board.
- board_change_enable  in  1  write strobe from game_logic.
- board_change_addr  in  6  square address {row[2:0], col[2:0]}. Row 0 = rank 8, row 7 = rank 1, col 0 = file a.
- board_change_piece  in  4  value to write. Bit 3 = color (0 white, 1 black), bits 2:0 = type.
- board_out  out  256  flattened board. Square i occupies [4i+3:4i].
- rd_addr  in  6  display read address.
- rd_piece  out  4  registered contents of rd_addr.
- busy  out  1  high while the init sequence runs.
- write_count  out  16  number of accepted writes since the last init.
- write_dropped  out  1  sticky flag: a write was rejected.

Behaviour:

Piece codes:
- NONE=0, PAWN=1, KNIGHT=2, BISHOP=3, ROOK=4, QUEEN=5, KING=6. Code 7 is stored as-is, with no check.

Reset (async assert on RESET_N low):
- All squares = 4'b0000, rd_piece = 0, write_count = 0, write_dropped = 0.
- state = INIT, init_ptr = 0, busy = 1.
- Release is sampled by CLK. Reset asserted mid-INIT or mid-IDLE immediately produces the same values above.

State INIT:
- Each rising edge writes the start value of square init_ptr, then init_ptr increments.
- On the edge that writes square 63: state goes to IDLE and busy goes to 0 at that edge.
- busy is therefore high for exactly 64 edges after reset release.
- Start values:
  - row 0 = 4'hC,A,B,D,E,B,A,C (black R N B Q K B N R)
  - row 1 = 4'h9 ×8
  - rows 2–5 = 0
  - row 6 = 4'h1 ×8
  - row 7 = 4'h4,2,3,5,6,3,2,4
- With CLEAR_ONLY=1, every square is written 0.
- board_change_enable during INIT: the write is ignored and write_dropped is set.
- new_game during INIT: init_ptr restarts at 0; busy stays high.

State IDLE:
- board_change_enable=1: the square at board_change_addr takes board_change_piece on that edge. board_out shows it immediately after that edge (no extra latency). write_count increments and saturates at 16'hFFFF.
- new_game=1: next state is INIT with init_ptr=0, write_count cleared, busy=1 from that edge.
- new_game together with board_change_enable on the same edge: new_game wins. The write is dropped and write_dropped is set.
- Back-to-back writes on consecutive cycles are all accepted. A repeated address simply overwrites.

Read port:
- rd_piece is registered with 1-cycle latency.
- Read-before-write: if rd_addr equals a square written on the same edge, rd_piece shows the old value. The new value appears on the following cycle's read.
- The read port is active in all states. During INIT it returns the partially loaded board.

Other:
- write_dropped clears only on reset.
- board_out is driven directly from the storage registers, with no combinational path from inputs.

Test Plan:
1. Release RESET_N, count edges → busy high for exactly 64 edges. Then board_out[3:0]=4'hC, square 4=4'hE, square 52=4'h1, square 60=4'h6, square 59=4'h5, square 35=4'h0. write_count=0.
2. In IDLE, write addr 52←0 then addr 36←4'h1 on consecutive cycles → both visible on board_out the edge after each write. write_count=2, write_dropped=0.
3. Set rd_addr=36 and write 36←4'h5 on the same edge → rd_piece=4'h1 next cycle, 4'h5 the cycle after.
4. Assert board_change_enable at cycle 10 of INIT → square unchanged, write_dropped=1, init still finishes at edge 64.
5. In IDLE, assert new_game together with a write to 0←4'h6 → write dropped, write_dropped=1. busy high for 64 edges, square 0 returns to 4'hC, write_count=0.
6. Assert RESET_N low mid-INIT (ptr≈30) for 5 ns between edges → board_out is all-zero immediately, busy=1. After release, the full 64-edge init completes correctly. Repeat with CLEAR_ONLY=1 → board_out all zero after init.

Source files
------------

// File: rtl/board_store.sv
// board_store: 64-square chess board storage.
// Receives square writes from game_logic, presents the whole board as a
// flattened bus, reloads the start position one square per clock after
// reset or new_game, and offers a registered single-square read port.
module board_store #(
  parameter int PIECE_W    = 4,
  parameter bit CLEAR_ONLY = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    new_game,
  input  logic                    board_change_enable,
  input  logic [5:0]              board_change_addr,
  input  logic [PIECE_W-1:0]      board_change_piece,
  output logic [64*PIECE_W-1:0]   board_out,
  input  logic [5:0]              rd_addr,
  output logic [PIECE_W-1:0]      rd_piece,
  output logic                    busy,
  output logic [15:0]             write_count,
  output logic                    write_dropped
);

  // Piece type codes; bit 3 of a square carries the colour (1 = black).
  localparam logic [2:0] P_NONE   = 3'd0;
  localparam logic [2:0] P_PAWN   = 3'd1;
  localparam logic [2:0] P_KNIGHT = 3'd2;
  localparam logic [2:0] P_BISHOP = 3'd3;
  localparam logic [2:0] P_ROOK   = 3'd4;
  localparam logic [2:0] P_QUEEN  = 3'd5;
  localparam logic [2:0] P_KING   = 3'd6;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [64*PIECE_W-1:0] board_q;
  logic [5:0]           init_ptr_q;
  logic [PIECE_W-1:0]   init_value;
  logic                 init_we;
  logic                 user_we;
  logic                 drop_write;

  // Back-rank piece for a given file (a..h).
  function automatic logic [2:0] back_rank(input logic [2:0] col);
    case (col)
      3'd0, 3'd7: back_rank = P_ROOK;
      3'd1, 3'd6: back_rank = P_KNIGHT;
      3'd2, 3'd5: back_rank = P_BISHOP;
      3'd3:       back_rank = P_QUEEN;
      default:    back_rank = P_KING;
    endcase
  endfunction

  // Standard start position. Row 0 is rank 8 (black back rank).
  function automatic logic [PIECE_W-1:0] start_value(input logic [5:0] sq);
    case (sq[5:3])
      3'd0:    start_value = {1'b1, back_rank(sq[2:0])};
      3'd1:    start_value = {1'b1, P_PAWN};
      3'd6:    start_value = {1'b0, P_PAWN};
      3'd7:    start_value = {1'b0, back_rank(sq[2:0])};
      default: start_value = {1'b0, P_NONE};
    endcase
  endfunction

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next state: INIT runs until square 63 is loaded; new_game restarts it.
  always_comb begin
    // NOTE: default assignment first so no path through this block leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_INIT: if (!new_game && init_ptr_q == 6'd63) state_d = ST_IDLE;
      ST_IDLE: if (new_game) state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs and write qualifiers decoded from the current state.
  always_comb begin
    busy       = (state_q == ST_INIT);
    init_we    = busy && !new_game;
    user_we    = !busy && !new_game && board_change_enable;
    drop_write = board_change_enable && (busy || new_game);
    init_value = CLEAR_ONLY ? '0 : start_value(init_ptr_q);
  end

  // Board storage, init pointer, read port and write bookkeeping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the board is a register array, not RAM, so it can and must clear on reset.
      board_q       <= '0;
      init_ptr_q    <= '0;
      rd_piece      <= '0;
      write_count   <= '0;
      write_dropped <= 1'b0;
    end else begin
      // NOTE: non-blocking reads of board_q see the pre-edge value, giving read-before-write.
      rd_piece <= board_q[int'(rd_addr)*PIECE_W +: PIECE_W];

      if (init_we)
        board_q[int'(init_ptr_q)*PIECE_W +: PIECE_W] <= init_value;
      else if (user_we)
        board_q[int'(board_change_addr)*PIECE_W +: PIECE_W] <= board_change_piece;

      // Pointer wraps 63 -> 0 as the last square loads, leaving it ready for the next init.
      if (new_game)  init_ptr_q <= '0;
      else if (busy) init_ptr_q <= init_ptr_q + 6'd1;

      if (new_game)
        write_count <= '0;
      else if (user_we && write_count != 16'hFFFF)
        write_count <= write_count + 16'd1;

      if (drop_write) write_dropped <= 1'b1;
    end
  end

  assign board_out = board_q;

endmodule

// File: tb/tb_board_store.sv
// tb_board_store: randomized self-checking bench for board_store.
// A board-level model (arrays of squares, a remaining-init counter) is
// advanced on every clock edge and compared with both a start-position
// instance and a CLEAR_ONLY instance on every falling edge.
module tb_board_store;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         new_game;
  logic         board_change_enable;
  logic [5:0]   board_change_addr;
  logic [3:0]   board_change_piece;
  logic [5:0]   rd_addr;
  logic [255:0] board_out,     board_out_c;
  logic [3:0]   rd_piece,      rd_piece_c;
  logic         busy,          busy_c;
  logic [15:0]  write_count,   write_count_c;
  logic         write_dropped, write_dropped_c;

  always #5 CLK = ~CLK;

  board_store #(.PIECE_W(4), .CLEAR_ONLY(1'b0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .new_game(new_game),
    .board_change_enable(board_change_enable), .board_change_addr(board_change_addr),
    .board_change_piece(board_change_piece), .board_out(board_out),
    .rd_addr(rd_addr), .rd_piece(rd_piece), .busy(busy),
    .write_count(write_count), .write_dropped(write_dropped)
  );

  board_store #(.PIECE_W(4), .CLEAR_ONLY(1'b1)) dut_clr (
    .CLK(CLK), .RESET_N(RESET_N), .new_game(new_game),
    .board_change_enable(board_change_enable), .board_change_addr(board_change_addr),
    .board_change_piece(board_change_piece), .board_out(board_out_c),
    .rd_addr(rd_addr), .rd_piece(rd_piece_c), .busy(busy_c),
    .write_count(write_count_c), .write_dropped(write_dropped_c)
  );

  // ---------------- behavioural model ----------------
  logic [3:0] mb [64];   // start-position board
  logic [3:0] cb [64];   // CLEAR_ONLY board
  int         m_left;    // squares still to load; 0 means idle
  int         m_wc;
  bit         m_drop;
  logic [3:0] m_rd, m_rd_c;

  int  tests = 0;
  int  fails = 0;
  bit  chk_en = 1'b0;

  function automatic logic [3:0] start_sq(input int sq);
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};  // R N B Q K B N R
    int row = sq / 8;
    int col = sq % 8;
    case (row)
      0:       return 4'(8 + back[col]);
      1:       return 4'h9;
      6:       return 4'h1;
      7:       return 4'(back[col]);
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [255:0] flat(input logic [3:0] b [64]);
    logic [255:0] v;
    for (int i = 0; i < 64; i++) v[4*i +: 4] = b[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin mb[i] = 4'h0; cb[i] = 4'h0; end
    m_left = 64; m_wc = 0; m_drop = 1'b0; m_rd = 4'h0; m_rd_c = 4'h0;
  endtask

  // One rising edge with the inputs currently applied.
  task automatic model_edge();
    int sq;
    m_rd   = mb[rd_addr];
    m_rd_c = cb[rd_addr];
    if (board_change_enable && (m_left > 0 || new_game)) m_drop = 1'b1;
    if (new_game) begin
      m_left = 64;
      m_wc   = 0;
    end else if (m_left > 0) begin
      sq = 64 - m_left;
      mb[sq] = start_sq(sq);
      cb[sq] = 4'h0;
      m_left--;
    end else if (board_change_enable) begin
      mb[board_change_addr] = board_change_piece;
      cb[board_change_addr] = board_change_piece;
      if (m_wc < 65535) m_wc++;
    end
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("board_out",       board_out,       flat(mb));
      check("board_out_clr",   board_out_c,     flat(cb));
      check("busy",            256'(busy),      256'(m_left > 0));
      check("busy_clr",        256'(busy_c),    256'(m_left > 0));
      check("write_count",     256'(write_count),   256'(m_wc));
      check("write_count_clr", 256'(write_count_c), 256'(m_wc));
      check("write_dropped",   256'(write_dropped),   256'(m_drop));
      check("write_dropped_c", 256'(write_dropped_c), 256'(m_drop));
      check("rd_piece",        256'(rd_piece),   256'(m_rd));
      check("rd_piece_clr",    256'(rd_piece_c), 256'(m_rd_c));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit ng, input bit we, input logic [5:0] a,
                      input logic [3:0] p, input logic [5:0] ra);
    new_game            = ng;
    board_change_enable = we;
    board_change_addr   = a;
    board_change_piece  = p;
    rd_addr             = ra;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'd0, 4'd0, rd_addr);
  endtask

  // Count busy edges until init ends, bounded.
  task automatic run_init(input int already, output int n);
    n = already;
    while (busy && n < 200) begin
      idle();
      n++;
    end
  endtask

  // Reset pulse of 5 ns between two rising edges (caller sits 1 ns after an edge).
  task automatic reset_pulse();
    RESET_N = 1'b0;
    model_reset();
    #1;
    check("rst_board_zero",     board_out,   256'd0);
    check("rst_board_zero_clr", board_out_c, 256'd0);
    check("rst_busy",           256'(busy),  256'd1);
    #4;
    RESET_N = 1'b1;
  endtask

  function automatic logic [3:0] sq_of(input logic [255:0] b, input int i);
    return b[4*i +: 4];
  endfunction

  int n;

  initial begin
    RESET_N = 1'b1; new_game = 1'b0; board_change_enable = 1'b0;
    board_change_addr = '0; board_change_piece = '0; rd_addr = '0;
    #1;
    RESET_N = 1'b0;
    model_reset();
    chk_en = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    check("reset_busy", 256'(busy), 256'd1);
    check("reset_wc",   256'(write_count), 256'd0);
    RESET_N = 1'b1;

    // 1: first init after reset release
    run_init(0, n);
    check("init_len_reset", 256'(n), 256'd64);
    check("sq0",  256'(sq_of(board_out, 0)),  256'hC);
    check("sq4",  256'(sq_of(board_out, 4)),  256'hE);
    check("sq52", 256'(sq_of(board_out, 52)), 256'h1);
    check("sq60", 256'(sq_of(board_out, 60)), 256'h6);
    check("sq59", 256'(sq_of(board_out, 59)), 256'h5);
    check("sq35", 256'(sq_of(board_out, 35)), 256'h0);
    check("mdl_sq3", 256'(mb[3]), 256'hD);
    check("mdl_sq9", 256'(mb[9]), 256'h9);
    check("wc_after_init", 256'(write_count), 256'd0);

    // 2: back-to-back writes, visible right after their edge
    step(1'b0, 1'b1, 6'd52, 4'h0, 6'd0);
    check("wr52", 256'(sq_of(board_out, 52)), 256'h0);
    step(1'b0, 1'b1, 6'd36, 4'h1, 6'd0);
    check("wr36", 256'(sq_of(board_out, 36)), 256'h1);
    check("wc_two",     256'(write_count),   256'd2);
    check("no_drop",    256'(write_dropped), 256'd0);

    // 3: read-before-write on the same square
    step(1'b0, 1'b1, 6'd36, 4'h5, 6'd36);
    check("rbw_old", 256'(rd_piece), 256'h1);
    step(1'b0, 1'b0, 6'd0, 4'h0, 6'd36);
    check("rbw_new", 256'(rd_piece), 256'h5);

    // 5: new_game beats a simultaneous write
    step(1'b1, 1'b1, 6'd0, 4'h6, 6'd0);
    check("ng_drop", 256'(write_dropped), 256'd1);
    check("ng_busy", 256'(busy), 256'd1);
    run_init(0, n);
    check("init_len_ng", 256'(n), 256'd64);
    check("ng_sq0", 256'(sq_of(board_out, 0)), 256'hC);
    check("ng_wc",  256'(write_count), 256'd0);

    // 6: reset in the middle of an init
    step(1'b1, 1'b0, 6'd0, 4'h0, 6'd0);
    repeat (30) idle();
    reset_pulse();
    run_init(0, n);
    check("init_len_rst", 256'(n), 256'd64);
    check("rst_sq0",  256'(sq_of(board_out, 0)),  256'hC);
    check("rst_sq60", 256'(sq_of(board_out, 60)), 256'h6);
    check("clr_all_zero", board_out_c, 256'd0);
    check("rst_drop_clear", 256'(write_dropped), 256'd0);

    // 4: write attempt on the 10th edge of an init
    step(1'b1, 1'b0, 6'd0, 4'h0, 6'd0);
    repeat (9) idle();
    step(1'b0, 1'b1, 6'd63, 4'h7, 6'd0);
    check("init_wr_ignored", 256'(sq_of(board_out, 63)), 256'h4);
    check("init_wr_drop",    256'(write_dropped), 256'd1);
    run_init(10, n);
    check("init_len_drop", 256'(n), 256'd64);

    // Randomized traffic with occasional new_game and reset pulses
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) reset_pulse();
      else step(r < 10, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
    end

    // Saturation of write_count
    step(1'b1, 1'b0, 6'd0, 4'h0, 6'd0);
    run_init(0, n);
    check("init_len_sat", 256'(n), 256'd64);
    for (int i = 0; i < 65540; i++)
      step(1'b0, 1'b1, 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
           6'($urandom_range(0, 63)));
    check("wc_saturated", 256'(write_count), 256'hFFFF);

    @(negedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
